serial_adder_seq: RTL and testbench

- Bit-serial N-bit adder built around the team's 1-bit full-adder cell `adder1` (inputs a, b, c; outputs y = sum bit, z = carry-out), which it instantiates exactly once.
- Loads two WIDTH-bit operands and a carry-in, then feeds the cell one bit pair per clock, LSB first, holding the carry in a flip-flop.
- Assembles the WIDTH-bit sum and final carry-out, and reports completion with a start/done handshake.
- Sits directly upstream of the full-adder cell as its sequencing and feeding stage; it is the smallest multi-bit arithmetic datapath in the TP set.

---
 rtl/serial_adder_seq_if.sv | 29 ++
 rtl/serial_adder_seq.sv | 115 +++++++++++
 tb/tb_serial_adder_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_seq_if
// Brief    : Start/done handshake and operand/result bundle for serial_adder_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum, cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_seq (with its 1-bit cell adder1)
// Brief    : Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module adder1 (
    input  wire logic a,
    input  wire logic b,
    input  wire logic c,
    output wire logic y,
    output wire logic z
);
    assign y = a ^ b ^ c;
    assign z = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    serial_adder_seq_if.slave bus
);
    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_y;
    logic               w_z;
    logic               w_load;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_next;

    adder1 u_cell (
        .a (r_a_sh[0]),
        .b (r_b_sh[0]),
        .c (r_carry),
        .y (w_y),
        .z (w_z)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_y) << (WIDTH - 1));
    assign w_load     = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= bus.a_in;
            r_b_sh  <= bus.b_in;
            r_acc   <= '0;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_acc   <= w_acc_next;
            r_carry <= w_z;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            // Results publish only on the final bit so they are never partial.
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_z;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_seq
// Brief    : Self-checking bench for serial_adder_seq at WIDTH=8 and WIDTH=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;
    logic clk = 1'b0;
    logic rst;

    serial_adder_seq_if #(.WIDTH(8)) bus8 ();
    serial_adder_seq_if #(.WIDTH(1)) bus1 ();

    serial_adder_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_adder_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb8[$];
    logic [1:0] sb1[$];

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.start = 1'b1;
        bus8.a_in  = a;
        bus8.b_in  = b;
        bus8.cin   = c;
        sb8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a_in  = 8'($urandom);
        bus8.b_in  = 8'($urandom);
        bus8.cin   = 1'($urandom);
    endtask

    // cyc = index of the negedge (current one = 1) at which done is seen, -1 on timeout.
    task automatic wait8(input int limit, output int cyc, output logic [8:0] got, output int nb);
        cyc = -1;
        nb  = 0;
        got = 'x;
        for (int i = 1; i <= limit; i++) begin
            if (bus8.done === 1'b1) begin
                cyc = i;
                got = {bus8.cout, bus8.sum};
                break;
            end
            if (bus8.busy === 1'b1) nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
        total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done8: got %b want 0", bus8.done); end
        total++; if ({bus8.cout, bus8.sum} !== 9'h000) begin bad++; $display("FAIL reset_result8: got %h want 000", {bus8.cout, bus8.sum}); end
        total++; if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'b0000) begin bad++; $display("FAIL reset_w1: got %b want 0000", {bus1.busy, bus1.done, bus1.cout, bus1.sum}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc; int nb; logic [8:0] got; logic [8:0] exp;
        issue8(8'h0F, 8'h01, 1'b0);
        wait8(40, cyc, got, nb);
        exp = sb8.pop_front();
        total++; if (cyc !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", cyc); end
        total++; if (nb !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
        total++; if (got !== exp) begin bad++; $display("FAIL basic_result: got %h want %h", got, exp); end
        @(negedge clk);
        total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", bus8.done); end
        total++; if ({bus8.cout, bus8.sum} !== exp) begin bad++; $display("FAIL basic_hold: got %h want %h", {bus8.cout, bus8.sum}, exp); end
    endtask

    task automatic test_ripple;
        int cyc; int nb; logic [8:0] got; logic [8:0] exp;
        logic [7:0] av[2] = '{8'hFF, 8'hFF};
        logic [7:0] bv[2] = '{8'h01, 8'hFF};
        logic       cv[2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            issue8(av[k], bv[k], cv[k]);
            wait8(40, cyc, got, nb);
            exp = sb8.pop_front();
            total++; if (cyc !== 9) begin bad++; $display("FAIL ripple_latency%0d: got %0d want 9", k, cyc); end
            total++; if (got !== exp) begin bad++; $display("FAIL ripple_result%0d: got %h want %h", k, got, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_start;
        int cyc; int nb; int extra; logic [8:0] got; logic [8:0] exp;
        issue8(8'h12, 8'h34, 1'b0);
        for (int r = 1; r <= 5; r++) begin
            bus8.start = (r == 3 || r == 5);
            bus8.a_in  = (r == 3 || r == 5) ? 8'hAA : 8'($urandom);
            bus8.b_in  = (r == 3 || r == 5) ? 8'h55 : 8'($urandom);
            @(negedge clk);
        end
        bus8.start = 1'b0;
        wait8(40, cyc, got, nb);
        exp = sb8.pop_front();
        total++; if (cyc !== 4) begin bad++; $display("FAIL ignored_latency: got %0d want 4", cyc); end
        total++; if (got !== exp) begin bad++; $display("FAIL ignored_result: got %h want %h", got, exp); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ignored_extra_activity: got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        int cyc; int nb; logic [8:0] got; logic [8:0] exp;
        issue8(8'h01, 8'h02, 1'b0);
        repeat (7) @(negedge clk);
        bus8.start = 1'b1;
        bus8.a_in  = 8'h80;
        bus8.b_in  = 8'h80;
        bus8.cin   = 1'b0;
        sb8.push_back(9'h080 + 9'h080);
        @(negedge clk);
        exp = sb8.pop_front();
        total++; if (bus8.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", bus8.done); end
        total++; if ({bus8.cout, bus8.sum} !== exp) begin bad++; $display("FAIL b2b_first_result: got %h want %h", {bus8.cout, bus8.sum}, exp); end
        @(negedge clk);
        bus8.start = 1'b0;
        total++; if ({bus8.busy, bus8.done} !== 2'b10) begin bad++; $display("FAIL b2b_busy_rise: got %b want 10", {bus8.busy, bus8.done}); end
        wait8(40, cyc, got, nb);
        exp = sb8.pop_front();
        total++; if (cyc !== 9) begin bad++; $display("FAIL b2b_second_latency: got %0d want 9", cyc); end
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_second_result: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc; int nb; int ndone; logic [8:0] got; logic [8:0] exp;
        issue8(8'h7F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb8.pop_back());
        total++; if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h000) begin bad++; $display("FAIL midreset_state: got %h want 000", {bus8.busy, bus8.done, bus8.cout, bus8.sum}); end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
        issue8(8'h7F, 8'h01, 1'b0);
        wait8(40, cyc, got, nb);
        exp = sb8.pop_front();
        total++; if (cyc !== 9) begin bad++; $display("FAIL midreset_fresh_latency: got %0d want 9", cyc); end
        total++; if (got !== exp) begin bad++; $display("FAIL midreset_fresh_result: got %h want %h", got, exp); end
        @(negedge clk);
    endtask

    task automatic test_width1;
        int cyc; logic [1:0] got; logic [1:0] exp; logic [2:0] v;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            bus1.start = 1'b1;
            bus1.a_in  = v[2];
            bus1.b_in  = v[1];
            bus1.cin   = v[0];
            sb1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
            @(negedge clk);
            bus1.start = 1'b0;
            bus1.a_in  = 1'($urandom);
            bus1.b_in  = 1'($urandom);
            cyc = -1;
            got = 'x;
            for (int i = 1; i <= 10; i++) begin
                if (bus1.done === 1'b1) begin cyc = i; got = {bus1.cout, bus1.sum}; break; end
                @(negedge clk);
            end
            exp = sb1.pop_front();
            total++; if (cyc !== 2) begin bad++; $display("FAIL w1_latency_%0d: got %0d want 2", k, cyc); end
            total++; if (got !== exp) begin bad++; $display("FAIL w1_result_%0d: got %b want %b", k, got, exp); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_ripple;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_width1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
